// File: rtl/zicsr_csr_unit_if.sv
// Request/response channel between the issuing stage and the ZICSR execution unit.
// The master issues CSR instructions and consumes responses; the slave executes them.
interface zicsr_csr_unit_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      uimm;
  logic            rs1_is_x0;
  logic            rd_is_x0;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  modport master (
    output req_valid, funct3, csr_addr, rs1_val, uimm, rs1_is_x0, rd_is_x0, flush, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_illegal
  );

  modport slave (
    input  req_valid, funct3, csr_addr, rs1_val, uimm, rs1_is_x0, rd_is_x0, flush, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_illegal
  );
endinterface

// File: rtl/zicsr_csr_unit.sv
// ZICSR execution unit: holds the CSR storage, runs CSRRW/S/C(I) instructions as a
// four-state sequence and returns the old value (or an illegal flag) on a valid/ready channel.
package zicsr_type_pkg;
  localparam int unsigned CSR_XLEN = 32;

  typedef struct packed {
    logic [11:0]         name;
    logic [CSR_XLEN-1:0] default_value;
    logic                write_en;
    logic                read_en;
    logic                internal_write_en;
  } csr_ctrl_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_COMMIT,
    ST_RESP
  } state_t;
endpackage

module zicsr_csr_unit
  import zicsr_type_pkg::*;
#(
  parameter int XLEN    = CSR_XLEN,
  parameter int NUM_CSR = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  zicsr_csr_unit_if.slave                bus,
  input  csr_ctrl_t [NUM_CSR-1:0]        csr_ctrl,
  input  logic [NUM_CSR-1:0]             int_we,
  input  logic [NUM_CSR-1:0][XLEN-1:0]   int_wdata,
  output logic [NUM_CSR-1:0][XLEN-1:0]   csr_q
);

  localparam int IDX_W = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

  state_t state;

  // Latched request fields
  logic [2:0]       funct3_q;
  logic [11:0]      addr_q;
  logic [XLEN-1:0]  rs1_q;
  logic [4:0]       uimm_q;
  logic             rs1_x0_q;
  logic             rd_x0_q;

  // Execution results carried from EXEC into COMMIT
  logic [IDX_W-1:0] idx_q;
  logic             illegal_q;
  logic             do_wr_q;
  logic [XLEN-1:0]  old_q;
  logic [XLEN-1:0]  new_q;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [XLEN-1:0]  src;
  logic             is_rw;
  logic             src_nz;
  logic             do_wr;
  logic             do_rd;
  logic             illegal;
  logic [XLEN-1:0]  old_val;
  logic [XLEN-1:0]  new_val;

  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so no latch is inferred.
    hit     = 1'b0;
    hit_idx = '0;
    // Walk downwards so the lowest matching index is the one that sticks.
    for (int i = NUM_CSR - 1; i >= 0; i--) begin
      if (csr_ctrl[i].name == addr_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end

    src     = funct3_q[2] ? {{(XLEN-5){1'b0}}, uimm_q} : rs1_q;
    is_rw   = (funct3_q[1:0] == 2'b01);
    src_nz  = funct3_q[2] ? (uimm_q != 5'd0) : !rs1_x0_q;
    do_wr   = is_rw || src_nz;
    do_rd   = !(is_rw && rd_x0_q);
    old_val = hit ? csr_q[hit_idx] : '0;

    illegal = !hit
           || (funct3_q[1:0] == 2'b00)
           || (do_wr && !csr_ctrl[hit_idx].write_en)
           || (do_rd && !csr_ctrl[hit_idx].read_en);

    case (funct3_q[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the CSR array is reset explicitly because its contents are architecturally visible on csr_q.
      state            <= ST_INIT;
      csr_q            <= '0;
      bus.req_ready    <= 1'b0;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_illegal <= 1'b0;
      funct3_q         <= '0;
      addr_q           <= '0;
      rs1_q            <= '0;
      uimm_q           <= '0;
      rs1_x0_q         <= 1'b0;
      rd_x0_q          <= 1'b0;
      idx_q            <= '0;
      illegal_q        <= 1'b0;
      do_wr_q          <= 1'b0;
      old_q            <= '0;
      new_q            <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          for (int i = 0; i < NUM_CSR; i++) begin
            csr_q[i] <= csr_ctrl[i].default_value[XLEN-1:0];
          end
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end

        ST_IDLE: begin
          if (bus.req_valid) begin
            funct3_q      <= bus.funct3;
            addr_q        <= bus.csr_addr;
            rs1_q         <= bus.rs1_val;
            uimm_q        <= bus.uimm;
            rs1_x0_q      <= bus.rs1_is_x0;
            rd_x0_q       <= bus.rd_is_x0;
            bus.req_ready <= 1'b0;
            state         <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (bus.flush) begin
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            idx_q     <= hit_idx;
            illegal_q <= illegal;
            do_wr_q   <= do_wr;
            old_q     <= old_val;
            new_q     <= new_val;
            state     <= ST_COMMIT;
          end
        end

        ST_COMMIT: begin
          if (!illegal_q && do_wr_q) begin
            csr_q[idx_q] <= new_q;
          end
          bus.resp_valid   <= 1'b1;
          bus.resp_rdata   <= illegal_q ? '0 : old_q;
          bus.resp_illegal <= illegal_q;
          state            <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= ST_IDLE;
          end
        end

        default: begin
          bus.req_ready <= 1'b0;
          state         <= ST_INIT;
        end
      endcase

      // NOTE: this sits after the COMMIT write on purpose; the later non-blocking assignment to the
      // same CSR takes effect, so a coinciding hardware-side write wins over the instruction.
      if (state != ST_INIT) begin
        for (int i = 0; i < NUM_CSR; i++) begin
          if (int_we[i] && csr_ctrl[i].internal_write_en) begin
            csr_q[i] <= int_wdata[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_zicsr_csr_unit.sv
// Randomised scoreboard bench for zicsr_csr_unit: a sequential reference model predicts each
// response and the CSR contents; a free-running monitor checks responses as the unit presents them.
module tb_zicsr_csr_unit;
  import zicsr_type_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_CSR = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  zicsr_csr_unit_if #(.XLEN(XLEN)) bus ();

  csr_ctrl_t [NUM_CSR-1:0]         csr_ctrl;
  logic [NUM_CSR-1:0]              int_we;
  logic [NUM_CSR-1:0][XLEN-1:0]    int_wdata;
  logic [NUM_CSR-1:0][XLEN-1:0]    csr_q;

  zicsr_csr_unit #(.XLEN(XLEN), .NUM_CSR(NUM_CSR)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .csr_ctrl  (csr_ctrl),
    .int_we    (int_we),
    .int_wdata (int_wdata),
    .csr_q     (csr_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        illegal;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] model[NUM_CSR];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_vec();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CSR; i++) model[i] = csr_ctrl[i].default_value;
  endtask

  task automatic model_int(input int ii, input logic [31:0] data);
    if (csr_ctrl[ii].internal_write_en) model[ii] = data;
  endtask

  // Response monitor: pops the scoreboard on every accepted response, and checks that a
  // stalled response stays put while resp_ready is low.
  initial begin
    logic        stall_seen;
    logic [31:0] stall_rdata;
    logic        stall_ill;
    resp_t       e;
    stall_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          check("hold_valid", bus.resp_valid, 1'b1);
          check("hold_rdata", bus.resp_rdata, stall_rdata);
          check("hold_illegal", bus.resp_illegal, stall_ill);
        end
        if (bus.resp_valid && bus.resp_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_resp_queue_size", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_illegal", bus.resp_illegal, e.illegal);
          end
          stall_seen = 1'b0;
        end else if (bus.resp_valid) begin
          stall_seen  = 1'b1;
          stall_rdata = bus.resp_rdata;
          stall_ill   = bus.resp_illegal;
        end else begin
          stall_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("req_ready", bus.req_ready, 1'b1);
  endtask

  // One instruction: predict, drive, then compare the CSR array. k is the cycle (0 = accept)
  // in which a hardware-side write to CSR ii is strobed, or -1 for none.
  task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] uimm, input logic rs1x0, input logic rdx0,
                         input int k, input int ii, input logic [31:0] data,
                         input logic do_flush, input int stall);
    bit          found = 0;
    int          hi = 0;
    logic [31:0] src, old_v, new_v;
    bit          wr, rd, bad;
    resp_t       r;

    if (k == 0) model_int(ii, data);
    for (int i = 0; i < NUM_CSR; i++) begin
      if (!found && csr_ctrl[i].name == addr) begin
        found = 1;
        hi    = i;
      end
    end
    src   = f3[2] ? 32'(uimm) : rs1;
    wr    = (f3[1:0] == 2'd1) || (f3[2] ? (uimm != 0) : !rs1x0);
    rd    = !((f3[1:0] == 2'd1) && rdx0);
    old_v = found ? model[hi] : 32'd0;
    bad   = !found || (f3[1:0] == 2'd0)
         || (wr && !csr_ctrl[hi].write_en) || (rd && !csr_ctrl[hi].read_en);
    case (f3[1:0])
      2'd1:    new_v = src;
      2'd2:    new_v = old_v | src;
      default: new_v = old_v & ~src;
    endcase
    if (k == 1) model_int(ii, data);
    if (!do_flush) begin
      if (!bad && wr) model[hi] = new_v;
      r.rdata   = bad ? 32'd0 : old_v;
      r.illegal = bad;
      sb.push_back(r);
    end
    if (k >= 2) model_int(ii, data);

    bus.funct3    = f3;
    bus.csr_addr  = addr;
    bus.rs1_val   = rs1;
    bus.uimm      = uimm;
    bus.rs1_is_x0 = rs1x0;
    bus.rd_is_x0  = rdx0;
    int_wdata[ii] = data;
    for (int c = 0; c <= 3 + stall; c++) begin
      bus.req_valid  = (c == 0);
      bus.flush      = do_flush && (c == 1);
      int_we         = (c == k) ? NUM_CSR'(1 << ii) : '0;
      bus.resp_ready = (c >= 3 + stall);
      @(posedge clk);
      #1;
    end
    bus.req_valid  = 1'b0;
    bus.flush      = 1'b0;
    int_we         = '0;
    bus.resp_ready = 1'b1;
    wait_ready();
    check("csr_q_vs_model", csr_q, model_vec());
  endtask

  initial begin
    csr_ctrl[0] = '{name: 12'h000, default_value: 32'h0,    write_en: 1'b1, read_en: 1'b1, internal_write_en: 1'b1};
    csr_ctrl[1] = '{name: 12'h300, default_value: 32'h1880, write_en: 1'b1, read_en: 1'b1, internal_write_en: 1'b1};
    csr_ctrl[2] = '{name: 12'h305, default_value: 32'h0,    write_en: 1'b1, read_en: 1'b0, internal_write_en: 1'b0};
    csr_ctrl[3] = '{name: 12'hF14, default_value: 32'h0,    write_en: 1'b0, read_en: 1'b1, internal_write_en: 1'b0};
    int_we         = '0;
    int_wdata      = '0;
    bus.req_valid  = 1'b0;
    bus.funct3     = '0;
    bus.csr_addr   = '0;
    bus.rs1_val    = '0;
    bus.uimm       = '0;
    bus.rs1_is_x0  = 1'b0;
    bus.rd_is_x0   = 1'b0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;

    // Reset state and release
    repeat (3) @(posedge clk);
    #1;
    check("rst_csr_q", csr_q, '0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    reset = 1'b1;
    wait_ready();
    model_reset();
    check("defaults", csr_q, {32'h0, 32'h0, 32'h1880, 32'h0});

    // CSRRW then CSRRS on mstatus
    run_txn(3'b001, 12'h300, 32'hA5A5_0000, 5'd0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    check("mstatus_rw", csr_q[1], 32'hA5A5_0000);
    run_txn(3'b010, 12'h300, 32'h0000_0008, 5'd0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    check("mstatus_rs", csr_q[1], 32'hA5A5_0008);

    // CSRRC with rs1=x0 reads only; CSRRCI clears bit 3
    run_txn(3'b011, 12'h300, 32'h0, 5'd0, 1'b1, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    check("mstatus_rc_x0", csr_q[1], 32'hA5A5_0008);
    run_txn(3'b111, 12'h300, 32'h0, 5'd8, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    check("mstatus_rci", csr_q[1], 32'hA5A5_0000);

    // Illegal accesses and the legal write-only mtvec write
    run_txn(3'b001, 12'hF14, 32'h1234_5678, 5'd0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    run_txn(3'b010, 12'h305, 32'h0, 5'd0, 1'b1, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    run_txn(3'b001, 12'h7FF, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    run_txn(3'b100, 12'h300, 32'h5, 5'd3, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, 0);
    check("illegal_no_change", csr_q, {32'h0, 32'h0, 32'hA5A5_0000, 32'h0});
    run_txn(3'b001, 12'h305, 32'h0000_0100, 5'd0, 1'b0, 1'b1, -1, 0, 32'h0, 1'b0, 0);
    check("mtvec_rw_rd_x0", csr_q[2], 32'h0000_0100);

    // Flush in EXEC, then a response stalled for three cycles
    run_txn(3'b001, 12'h000, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b1, 0);
    check("flush_no_write", csr_q[0], 32'h0);
    run_txn(3'b010, 12'h300, 32'h0000_00F0, 5'd0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, 3);

    // Hardware-side writes colliding with the instruction
    run_txn(3'b001, 12'h300, 32'h1111_1111, 5'd0, 1'b0, 1'b0, 2, 1, 32'h2222_2222, 1'b0, 0);
    check("int_wins_commit", csr_q[1], 32'h2222_2222);
    run_txn(3'b001, 12'h300, 32'h3333_3333, 5'd0, 1'b0, 1'b0, 1, 1, 32'h4444_4444, 1'b0, 0);
    check("commit_after_exec_int", csr_q[1], 32'h3333_3333);
    run_txn(3'b010, 12'h000, 32'h0, 5'd0, 1'b1, 1'b0, 1, 0, 32'h0000_0055, 1'b0, 0);

    // Reset asserted while in COMMIT
    bus.funct3    = 3'b001;
    bus.csr_addr  = 12'h300;
    bus.rs1_val   = 32'h7777_7777;
    bus.rs1_is_x0 = 1'b0;
    bus.rd_is_x0  = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_csr_q", csr_q, '0);
    check("midrst_resp_valid", bus.resp_valid, 1'b0);
    check("midrst_req_ready", bus.req_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ready();
    model_reset();
    check("midrst_defaults", csr_q, model_vec());

    // Randomised traffic
    for (int t = 0; t < 80; t++) begin
      logic [11:0] addr;
      logic [31:0] rs1;
      logic        rs1x0;
      int          pick;
      pick = int'($urandom_range(0, 5));
      if (pick < NUM_CSR)  addr = csr_ctrl[pick].name;
      else if (pick == 4)  addr = 12'h7FF;
      else                 addr = 12'($urandom);
      rs1x0 = ($urandom_range(0, 3) == 0);
      rs1   = rs1x0 ? 32'h0 : $urandom;
      run_txn(3'($urandom), addr, rs1,
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              rs1x0, 1'($urandom),
              int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, NUM_CSR - 1)), $urandom,
              ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
